// File: rtl/otp_ctrl_pkg.sv
// otp_ctrl_pkg: shared definitions for the OTP controller and its macro initiator.
// Holds the macro command/error encodings, the sparse initiator FSM encoding, the
// default macro timeout and a small bit-width helper.
package otp_ctrl_pkg;

  // Bits needed to index 'value' entries (at least 1).
  function automatic int unsigned vbits(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  localparam int unsigned OtpCmdWidth = 2;
  localparam int unsigned OtpErrWidth = 3;

  typedef enum logic [OtpCmdWidth-1:0] {
    OtpRead  = 2'b00,
    OtpWrite = 2'b01,
    OtpInit  = 2'b11
  } otp_cmd_e;

  typedef enum logic [OtpErrWidth-1:0] {
    NoErr            = 3'h0,
    OtpCmdInvErr     = 3'h1,
    OtpInitErr       = 3'h2,
    OtpReadErr       = 3'h3,
    OtpReadUncorrErr = 3'h4,
    OtpReadCorrErr   = 3'h5,
    OtpWriteBlankErr = 3'h6,
    OtpWriteErr      = 3'h7
  } otp_err_e;

  localparam int unsigned OtpMacroTimeoutCycles = 1024;

  // Codewords are distinct non-zero Walsh functions of length 16, so every pair
  // differs in exactly 8 bits; a single upset can never land on another state.
  localparam int unsigned OtpInitStateWidth = 16;
  typedef enum logic [OtpInitStateWidth-1:0] {
    ResetSt    = 16'h5555,
    InitReqSt  = 16'h3333,
    InitWaitSt = 16'h0F0F,
    IdleSt     = 16'h00FF,
    CmdReqSt   = 16'h6666,
    CmdWaitSt  = 16'h5A5A,
    ErrorSt    = 16'h3C3C
  } otp_init_state_e;

endpackage

// File: rtl/otp_macro_initiator.sv
// otp_macro_initiator: command initiator for the OTP macro ready/valid interface.
// Issues the mandatory Init after reset, then serialises single upstream read/write
// requests to the macro, one outstanding at a time. Each wait for a macro response is
// guarded by a saturating timeout counter; protocol violations, fatal macro errors and
// timeouts end in a terminal error state that only reset leaves.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o           upstream request handshake
//   req_write_i/size_i/addr_i/wdata_i upstream request fields
//   resp_valid_o/rdata_o/err_o        one-cycle upstream response
//   init_done_o, fatal_o, timeout_o   status (init complete, terminal error, timeout cause)
//   otp_valid_o/otp_ready_i           macro command handshake
//   otp_cmd_o/size_o/addr_o/wdata_o   registered macro command fields
//   otp_valid_i/rdata_i/err_i         macro response channel
module otp_macro_initiator
  import otp_ctrl_pkg::*;
#(
  parameter int unsigned Width         = 16,
  parameter int unsigned Depth         = 1024,
  parameter int unsigned SizeWidth     = 2,
  parameter int unsigned TimeoutCycles = OtpMacroTimeoutCycles,
  localparam int unsigned AddrWidth    = vbits(Depth),
  localparam int unsigned IfWidth      = (2**SizeWidth) * Width
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [SizeWidth-1:0]   req_size_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [IfWidth-1:0]     req_wdata_i,
  output logic                   resp_valid_o,
  output logic [IfWidth-1:0]     resp_rdata_o,
  output logic [OtpErrWidth-1:0] resp_err_o,
  output logic                   init_done_o,
  output logic                   fatal_o,
  output logic                   timeout_o,
  output logic                   otp_valid_o,
  input  logic                   otp_ready_i,
  output logic [OtpCmdWidth-1:0] otp_cmd_o,
  output logic [SizeWidth-1:0]   otp_size_o,
  output logic [AddrWidth-1:0]   otp_addr_o,
  output logic [IfWidth-1:0]     otp_wdata_o,
  input  logic                   otp_valid_i,
  input  logic [IfWidth-1:0]     otp_rdata_i,
  input  logic [OtpErrWidth-1:0] otp_err_i
);

  localparam int unsigned CntWidth = vbits(TimeoutCycles);
  localparam int unsigned NumWords = 2**SizeWidth;
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  otp_init_state_e        r_state, w_state_d;
  logic [CntWidth-1:0]    r_cnt;
  otp_cmd_e               r_cmd;
  logic [SizeWidth-1:0]   r_size;
  logic [AddrWidth-1:0]   r_addr;
  logic [IfWidth-1:0]     r_wdata;
  logic                   r_init_done;
  logic                   r_timeout;
  logic                   r_resp_valid;
  logic [IfWidth-1:0]     r_resp_rdata;
  logic [OtpErrWidth-1:0] r_resp_err;

  logic               w_cnt_clr;
  logic               w_in_wait;
  logic               w_init_load;
  logic               w_cmd_capture;
  logic               w_init_ok;
  logic               w_timeout_hit;
  logic               w_resp_fire;
  logic [IfWidth-1:0] w_rdata_masked;

  always_comb begin
    w_state_d     = r_state;
    w_cnt_clr     = 1'b0;
    w_init_load   = 1'b0;
    w_cmd_capture = 1'b0;
    w_init_ok     = 1'b0;
    w_timeout_hit = 1'b0;
    w_resp_fire   = 1'b0;
    unique case (r_state)
      ResetSt: begin
        if (otp_valid_i) begin
          w_state_d = ErrorSt;
        end else begin
          w_state_d   = InitReqSt;
          w_init_load = 1'b1;
        end
      end
      InitReqSt: begin
        if (otp_valid_i) begin
          w_state_d = ErrorSt;
        end else if (otp_ready_i) begin
          w_state_d = InitWaitSt;
          w_cnt_clr = 1'b1;
        end
      end
      InitWaitSt: begin
        // A response in the same cycle as the last timeout count still wins.
        if (otp_valid_i) begin
          if (otp_err_i == NoErr) begin
            w_state_d = IdleSt;
            w_init_ok = 1'b1;
          end else begin
            w_state_d = ErrorSt;
          end
        end else if (r_cnt == TimeoutLast) begin
          w_state_d     = ErrorSt;
          w_timeout_hit = 1'b1;
        end
      end
      IdleSt: begin
        if (otp_valid_i) begin
          w_state_d = ErrorSt;
        end else if (req_valid_i) begin
          w_state_d     = CmdReqSt;
          w_cmd_capture = 1'b1;
        end
      end
      CmdReqSt: begin
        // The macro may stall the command indefinitely; no timeout here.
        if (otp_valid_i) begin
          w_state_d = ErrorSt;
        end else if (otp_ready_i) begin
          w_state_d = CmdWaitSt;
          w_cnt_clr = 1'b1;
        end
      end
      CmdWaitSt: begin
        if (otp_valid_i) begin
          if (otp_err_i == OtpCmdInvErr) begin
            w_state_d = ErrorSt;
          end else begin
            w_state_d   = IdleSt;
            w_resp_fire = 1'b1;
          end
        end else if (r_cnt == TimeoutLast) begin
          w_state_d     = ErrorSt;
          w_timeout_hit = 1'b1;
        end
      end
      ErrorSt: w_state_d = ErrorSt;
      default: w_state_d = ErrorSt;
    endcase
  end

  assign w_in_wait = (r_state == InitWaitSt) || (r_state == CmdWaitSt);

  // Only words 0..size carry data; writes return zero.
  always_comb begin
    w_rdata_masked = '0;
    if (r_cmd == OtpRead) begin
      for (int unsigned k = 0; k < NumWords; k++) begin
        if (SizeWidth'(k) <= r_size) begin
          w_rdata_masked[k*Width +: Width] = otp_rdata_i[k*Width +: Width];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ResetSt;
      r_cnt        <= '0;
      r_cmd        <= OtpRead;
      r_size       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_init_done  <= 1'b0;
      r_timeout    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_in_wait && (r_cnt != {CntWidth{1'b1}})) begin
        r_cnt <= r_cnt + CntWidth'(1);
      end
      if (w_init_load) begin
        r_cmd   <= OtpInit;
        r_size  <= '0;
        r_addr  <= '0;
        r_wdata <= '0;
      end else if (w_cmd_capture) begin
        r_cmd   <= req_write_i ? OtpWrite : OtpRead;
        r_size  <= req_size_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
      end
      if (w_init_ok) r_init_done <= 1'b1;
      if (w_timeout_hit) r_timeout <= 1'b1;
      r_resp_valid <= w_resp_fire;
      if (w_resp_fire) begin
        r_resp_rdata <= w_rdata_masked;
        r_resp_err   <= otp_err_i;
      end
    end
  end

  assign req_ready_o  = (r_state == IdleSt);
  assign otp_valid_o  = (r_state == InitReqSt) || (r_state == CmdReqSt);
  assign fatal_o      = (r_state == ErrorSt);
  assign timeout_o    = r_timeout;
  assign init_done_o  = r_init_done;
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_resp_rdata;
  assign resp_err_o   = r_resp_err;
  assign otp_cmd_o    = r_cmd;
  assign otp_size_o   = r_size;
  assign otp_addr_o   = r_addr;
  assign otp_wdata_o  = r_wdata;

endmodule

// File: tb/tb_otp_macro_initiator.sv
// tb_otp_macro_initiator: directed bench for otp_macro_initiator (TimeoutCycles = 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that point,
// before any input is updated, since no output depends combinationally on an input.
module tb_otp_macro_initiator;

  localparam int unsigned IfW = 64;
  localparam int unsigned AW  = 10;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           req_valid_i;
  logic           req_ready_o;
  logic           req_write_i;
  logic [1:0]     req_size_i;
  logic [AW-1:0]  req_addr_i;
  logic [IfW-1:0] req_wdata_i;
  logic           resp_valid_o;
  logic [IfW-1:0] resp_rdata_o;
  logic [2:0]     resp_err_o;
  logic           init_done_o;
  logic           fatal_o;
  logic           timeout_o;
  logic           otp_valid_o;
  logic           otp_ready_i;
  logic [1:0]     otp_cmd_o;
  logic [1:0]     otp_size_o;
  logic [AW-1:0]  otp_addr_o;
  logic [IfW-1:0] otp_wdata_o;
  logic           otp_valid_i;
  logic [IfW-1:0] otp_rdata_i;
  logic [2:0]     otp_err_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  otp_macro_initiator #(
    .TimeoutCycles(8)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_size_i   (req_size_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .init_done_o  (init_done_o),
    .fatal_o      (fatal_o),
    .timeout_o    (timeout_o),
    .otp_valid_o  (otp_valid_o),
    .otp_ready_i  (otp_ready_i),
    .otp_cmd_o    (otp_cmd_o),
    .otp_size_o   (otp_size_o),
    .otp_addr_o   (otp_addr_o),
    .otp_wdata_o  (otp_wdata_o),
    .otp_valid_i  (otp_valid_i),
    .otp_rdata_i  (otp_rdata_i),
    .otp_err_i    (otp_err_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reset for one edge and check that every output is cleared.
  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check({tag, "_rst_outs"},
          {resp_valid_o, init_done_o, fatal_o, timeout_o, otp_valid_o, req_ready_o}, 6'b0);
  endtask

  // Init handshake, three wait cycles, then a NoErr response.
  task automatic do_init(input string tag);
    tick();
    check({tag, "_init_cmd"}, {otp_valid_o, otp_cmd_o, otp_size_o, otp_addr_o}, {1'b1, 2'b11, 2'b0, 10'h0});
    otp_ready_i = 1'b1;
    tick();
    otp_ready_i = 1'b0;
    check({tag, "_init_wait"}, {otp_valid_o, init_done_o, req_ready_o}, 3'b000);
    tick();
    tick();
    otp_valid_i = 1'b1;
    otp_err_i   = 3'h0;
    tick();
    otp_valid_i = 1'b0;
    check({tag, "_init_done"}, {init_done_o, req_ready_o, fatal_o, timeout_o}, 4'b1100);
  endtask

  // Present one request while idle; returns right after the handshake edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic [AW-1:0] ad,
                       input logic [IfW-1:0] wd);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_size_i  = sz;
    req_addr_i  = ad;
    req_wdata_i = wd;
    tick();
    req_valid_i = 1'b0;
    req_wdata_i = '0;
  endtask

  logic stable;

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_size_i  = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    otp_ready_i = 1'b0;
    otp_valid_i = 1'b0;
    otp_rdata_i = '0;
    otp_err_i   = '0;
    tick();

    // Power-on reset and Init.
    do_reset("por");
    do_init("por");

    // Read addr 0x010 size 1; upper words of the macro data must be dropped.
    issue(1'b0, 2'd1, 10'h010, 64'h0);
    check("rd_cmd", {otp_valid_o, otp_cmd_o, otp_size_o, otp_addr_o, req_ready_o},
          {1'b1, 2'b00, 2'd1, 10'h010, 1'b0});
    otp_ready_i = 1'b1;
    tick();
    otp_ready_i = 1'b0;
    check("rd_wait", {otp_valid_o, resp_valid_o}, 2'b00);
    otp_valid_i = 1'b1;
    otp_rdata_i = 64'hFFFF_AAAA_BEEF_1234;
    otp_err_i   = 3'h0;
    tick();
    otp_valid_i = 1'b0;
    otp_rdata_i = '0;
    check("rd_resp_valid", {resp_valid_o, req_ready_o}, 2'b11);
    check("rd_resp_data", resp_rdata_o, 64'h0000_0000_BEEF_1234);
    check("rd_resp_err", resp_err_o, 3'h0);
    tick();
    check("rd_resp_pulse", resp_valid_o, 1'b0);

    // Write addr 0x3FC size 3 with a 20-cycle command stall, then WriteBlank error.
    issue(1'b1, 2'd3, 10'h3FC, 64'h0123_4567_89AB_CDEF);
    check("wr_cmd", {otp_valid_o, otp_cmd_o, otp_size_o, otp_addr_o}, {1'b1, 2'b01, 2'd3, 10'h3FC});
    check("wr_wdata", otp_wdata_o, 64'h0123_4567_89AB_CDEF);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (otp_valid_o !== 1'b1 || otp_cmd_o !== 2'b01 || otp_size_o !== 2'd3 ||
          otp_addr_o !== 10'h3FC || otp_wdata_o !== 64'h0123_4567_89AB_CDEF) stable = 1'b0;
    end
    check("stall_stable", stable, 1'b1);
    check("stall_no_timeout", {fatal_o, timeout_o}, 2'b00);
    otp_ready_i = 1'b1;
    tick();
    otp_ready_i = 1'b0;
    tick();
    otp_valid_i = 1'b1;
    otp_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
    otp_err_i   = 3'h6;
    tick();
    otp_valid_i = 1'b0;
    otp_err_i   = 3'h0;
    check("wr_resp", {resp_valid_o, resp_err_o, req_ready_o, fatal_o}, {1'b1, 3'h6, 1'b1, 1'b0});
    check("wr_resp_data", resp_rdata_o, 64'h0);

    // Read with no response: error exactly 8 wait cycles after acceptance.
    issue(1'b0, 2'd0, 10'h005, 64'h0);
    otp_ready_i = 1'b1;
    tick();
    otp_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("to_before", {fatal_o, timeout_o}, 2'b00);
    tick();
    check("to_fatal", {fatal_o, timeout_o, req_ready_o, otp_valid_o}, 4'b1100);
    tick();
    tick();
    check("to_sticky", {fatal_o, timeout_o, resp_valid_o}, 3'b110);

    // Reset recovers; Init is reissued.
    do_reset("rec");
    do_init("rec");

    // Spurious macro response while idle.
    otp_valid_i = 1'b1;
    tick();
    otp_valid_i = 1'b0;
    check("spur_fatal", {fatal_o, timeout_o, req_ready_o, otp_valid_o}, 4'b1000);
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    check("spur_terminal", {fatal_o, otp_valid_o, req_ready_o}, 3'b100);

    do_reset("spur");
    tick();
    check("spur_reinit", {otp_valid_o, otp_cmd_o, fatal_o, init_done_o}, {1'b1, 2'b11, 2'b00});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
